decode_stage: RTL

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/alu_pkg.sv | 48 ++++
 rtl/reg_file.sv | 66 ++++++
 rtl/decode_stage.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions between the decode and execute stages: the ALU
// operation encoding, the RV32I opcodes handled by this core, and the
// funct3/funct7 field values used to select an operation.
// No ports (package).
// ---------------------------------------------------------------------------
package alu_pkg;

  // ALU operation codes as carried on the decode -> execute bundle
  typedef enum logic [3:0] {
    ALU_ADD = 4'b0000,
    ALU_SUB = 4'b0001,
    ALU_XOR = 4'b0010,
    ALU_OR  = 4'b0011,
    ALU_AND = 4'b0100,
    ALU_SLT = 4'b0101,
    ALU_LLS = 4'b0110,
    ALU_LRS = 4'b0111,
    ALU_ARS = 4'b1000
  } alu_op_e;

  // Where the second ALU operand comes from
  typedef enum logic [1:0] {
    SRC2_REG   = 2'b00,
    SRC2_IMM   = 2'b01,
    SRC2_SHAMT = 2'b10
  } src2_sel_e;

  // Major opcodes
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

  // funct3 values
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_SLTU    = 3'b011;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;

  // funct7 values: BASE for the plain form, ALT selects SUB / arithmetic shift
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/reg_file.sv
// ---------------------------------------------------------------------------
// reg_file
// Architectural register file: two combinational read ports, one write
// port. x0 always reads as zero and ignores writes. A read of the register
// being written in the same cycle returns the incoming write data, so the
// decode stage sees the value that is committed at this clock edge.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset (clears all)
//   rs1_addr, rs1_data  read port 1
//   rs2_addr, rs2_data  read port 2
//   wr_en, wr_addr,
//   wr_data             write port (committed on rising clk edge)
// ---------------------------------------------------------------------------
module reg_file #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [4:0]      rs1_addr,
  output logic [XLEN-1:0] rs1_data,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs2_data,
  input  logic            wr_en,
  input  logic [4:0]      wr_addr,
  input  logic [XLEN-1:0] wr_data
);

  logic [XLEN-1:0] regs [NREGS];

  // Storage: reset clears every entry; writes to x0 are dropped
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en && (wr_addr != 5'd0)) begin
      regs[wr_addr] <= wr_data;
    end
  end

  // Read ports with write-through bypass
  always_comb begin
    rs1_data = '0;
    if (rs1_addr != 5'd0) begin
      if (wr_en && (wr_addr == rs1_addr)) begin
        rs1_data = wr_data;
      end else begin
        rs1_data = regs[rs1_addr];
      end
    end
  end

  always_comb begin
    rs2_data = '0;
    if (rs2_addr != 5'd0) begin
      if (wr_en && (wr_addr == rs2_addr)) begin
        rs2_data = wr_data;
      end else begin
        rs2_data = regs[rs2_addr];
      end
    end
  end

endmodule

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
// RV32I ALU-subset decoder with a single-entry output register. Accepts an
// instruction word via a valid/ready handshake, reads its source registers
// and presents an ALU bundle (operands, operation, destination) one cycle
// later. The bundle is held unchanged while execute stalls.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   in_valid/in_ready/in_instr   instruction input handshake
//   flush                        drop held bundle and block acceptance
//   wb_en/wb_rd/wb_data          register writeback port
//   out_valid/out_ready          bundle output handshake
//   out_operand1/out_operand2    ALU operands
//   out_operation                ALU operation (alu_pkg::alu_op_e)
//   out_rd                       destination register
//   out_illegal                  instruction not in the supported subset
// ---------------------------------------------------------------------------
module decode_stage
  import alu_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREGS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic            flush,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_operand1,
  output logic [XLEN-1:0] out_operand2,
  output logic [3:0]      out_operation,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic [4:0] rd;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign funct3 = in_instr[14:12];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];
  assign funct7 = in_instr[31:25];

  logic            accept;
  logic [XLEN-1:0] rs1_data;
  logic [XLEN-1:0] rs2_data;

  // A held bundle can be replaced in the same cycle it is consumed
  assign in_ready = !flush && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;

  reg_file #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_reg_file (
    .clk      (clk),
    .rst_n    (rst_n),
    .rs1_addr (rs1),
    .rs1_data (rs1_data),
    .rs2_addr (rs2),
    .rs2_data (rs2_data),
    .wr_en    (wb_en),
    .wr_addr  (wb_rd),
    .wr_data  (wb_data)
  );

  alu_op_e   dec_op;
  src2_sel_e dec_src2;
  logic      dec_illegal;

  // Instruction classification. Everything starts illegal and only the
  // supported encodings clear the flag; SLTU/SLTIU are deliberately left out.
  always_comb begin
    dec_op      = ALU_ADD;
    dec_src2    = SRC2_REG;
    dec_illegal = 1'b1;
    case (opcode)
      OPC_OP: begin
        dec_src2 = SRC2_REG;
        case (funct3)
          F3_ADD_SUB: begin
            if (funct7 == F7_BASE) begin
              dec_op = ALU_ADD; dec_illegal = 1'b0;
            end else if (funct7 == F7_ALT) begin
              dec_op = ALU_SUB; dec_illegal = 1'b0;
            end
          end
          F3_SLL: if (funct7 == F7_BASE) begin dec_op = ALU_LLS; dec_illegal = 1'b0; end
          F3_SLT: if (funct7 == F7_BASE) begin dec_op = ALU_SLT; dec_illegal = 1'b0; end
          F3_SLTU: dec_illegal = 1'b1;
          F3_XOR: if (funct7 == F7_BASE) begin dec_op = ALU_XOR; dec_illegal = 1'b0; end
          F3_SRL_SRA: begin
            if (funct7 == F7_BASE) begin
              dec_op = ALU_LRS; dec_illegal = 1'b0;
            end else if (funct7 == F7_ALT) begin
              dec_op = ALU_ARS; dec_illegal = 1'b0;
            end
          end
          F3_OR:  if (funct7 == F7_BASE) begin dec_op = ALU_OR;  dec_illegal = 1'b0; end
          F3_AND: if (funct7 == F7_BASE) begin dec_op = ALU_AND; dec_illegal = 1'b0; end
          default: dec_illegal = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        dec_src2 = SRC2_IMM;
        case (funct3)
          F3_ADD_SUB: begin dec_op = ALU_ADD; dec_illegal = 1'b0; end
          F3_SLT:     begin dec_op = ALU_SLT; dec_illegal = 1'b0; end
          F3_SLTU:    dec_illegal = 1'b1;
          F3_XOR:     begin dec_op = ALU_XOR; dec_illegal = 1'b0; end
          F3_OR:      begin dec_op = ALU_OR;  dec_illegal = 1'b0; end
          F3_AND:     begin dec_op = ALU_AND; dec_illegal = 1'b0; end
          F3_SLL: begin
            dec_src2 = SRC2_SHAMT;
            if (funct7 == F7_BASE) begin dec_op = ALU_LLS; dec_illegal = 1'b0; end
          end
          F3_SRL_SRA: begin
            dec_src2 = SRC2_SHAMT;
            if (funct7 == F7_BASE) begin
              dec_op = ALU_LRS; dec_illegal = 1'b0;
            end else if (funct7 == F7_ALT) begin
              dec_op = ALU_ARS; dec_illegal = 1'b0;
            end
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  alu_op_e         nxt_op;
  logic [XLEN-1:0] nxt_op1;
  logic [XLEN-1:0] nxt_op2;
  logic [4:0]      nxt_rd;

  // Bundle contents; an illegal instruction carries an all-zero payload
  always_comb begin
    nxt_op  = ALU_ADD;
    nxt_op1 = '0;
    nxt_op2 = '0;
    nxt_rd  = '0;
    if (!dec_illegal) begin
      nxt_op  = dec_op;
      nxt_op1 = rs1_data;
      nxt_rd  = rd;
      case (dec_src2)
        SRC2_IMM:   nxt_op2 = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
        SRC2_SHAMT: nxt_op2 = {{(XLEN-5){1'b0}}, in_instr[24:20]};
        default:    nxt_op2 = rs2_data;
      endcase
    end
  end

  // Output register. Operands are captured only on acceptance, so later
  // writebacks never disturb a stalled bundle. Flush takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid     <= 1'b0;
      out_operand1  <= '0;
      out_operand2  <= '0;
      out_operation <= 4'b0000;
      out_rd        <= '0;
      out_illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid     <= 1'b1;
      out_operand1  <= nxt_op1;
      out_operand2  <= nxt_op2;
      out_operation <= nxt_op;
      out_rd        <= nxt_rd;
      out_illegal   <= dec_illegal;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
